mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer sharing the CPU's single memory port between instruction fetch (IF) and load/store (LSU) requesters. One transaction is outstanding at a time. The LSU has priority, and a starvation counter guarantees fetch progress. The block sits between the IFU/MEMU stages and the memory interface, and owns the request/response handshakes on both sides.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; wstrb width is DATA_WIDTH/8
- STARVE_LIMIT, 4, consecutive LSU grants with IF pending before IF is forced

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_req_addr  in  ADDR_WIDTH  fetch address
- if_flush  in  1  discard the response of an accepted fetch (branch flush)
- if_resp_valid  out  1  fetch data valid, 1-cycle pulse
- if_resp_data  out  DATA_WIDTH  fetched instruction
- lsu_req_valid  in  1  data request
- lsu_req_ready  out  1  data request accepted this cycle
- lsu_req_addr  in  ADDR_WIDTH  data address
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_wdata  in  DATA_WIDTH  store data
- lsu_req_wstrb  in  DATA_WIDTH/8  byte enables
- lsu_resp_valid  out  1  load data / store ack, 1-cycle pulse
- lsu_resp_rdata  out  DATA_WIDTH  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb  out  as LSU  registered request fields (wen=0, wstrb=0 for fetch)
- mem_resp_valid  in  1  memory response (reads and writes)
- mem_resp_rdata  in  DATA_WIDTH  read data
- protocol_err  out  1  sticky: mem_resp_valid seen outside WAIT

## Operation
- States: IDLE, REQ (mem_req_valid held), WAIT (awaiting mem_resp_valid). A registered owner bit (IF/LSU) is kept with the state.
- IDLE: grant LSU if lsu_req_valid, unless IF is pending and starve_cnt == STARVE_LIMIT, in which case grant IF. Grant IF if only IF is valid.
  - The granted ready is asserted combinationally and only in IDLE. Request fields are captured into registers. Next state is REQ.
- REQ: mem_req_valid=1 with the registered fields held stable. On mem_req_ready, go to WAIT.
- WAIT: on mem_resp_valid, route mem_resp_rdata combinationally to the owner's resp_data. Pulse the owner's resp_valid in the same cycle, then go to IDLE.
- if_flush is sampled in REQ/WAIT with owner=IF and sets a registered drop flag. The flag is cleared on entry to IDLE.
  - While the flag is set, the transaction still completes on the memory side, but if_resp_valid is suppressed.
  - if_flush asserted in the same cycle as the response also suppresses that response.
  - if_flush in IDLE has no effect.
- starve_cnt, 0..STARVE_LIMIT, saturating:
  - Increments on an LSU grant while if_req_valid=1.
  - Cleared on any IF grant.
  - Cleared on any grant made while if_req_valid=0.
- Upstream requesters hold valid and fields stable until ready. The arbiter does not check this.
- mem_resp_valid in IDLE/REQ is ignored and sets protocol_err. protocol_err is cleared only by rst.

## Timing
- Reset values: state IDLE, owner IF, starve_cnt 0, drop 0, protocol_err 0. All ready, valid and resp outputs are 0. mem_req_* fields and resp data are 0.
- Cycle 0: accept (ready=1). Cycle 1: mem_req_valid=1. The earliest accept by memory is cycle 1, giving WAIT at cycle 2. The earliest response is cycle 2, with IDLE and the next accept at cycle 3.
  - Minimum turnaround is 3 cycles per transaction.
- The response path mem_resp → *_resp_* is combinational, zero added latency. There is no other combinational path from memory to the requesters.
- Ready toward upstream depends only on state, registered counters and the upstream valids. It never depends on mem_* inputs.
- rst mid-transaction: abandon it immediately, deliver no response, return to IDLE next cycle.

## Structure
- Shared package mem_arb_pkg:
  - state enum {IDLE, REQ, WAIT}.
  - owner encoding {OWNER_IF=0, OWNER_LSU=1}.
  - Request struct {addr, wen, wdata, wstrb}, parameterised by the default widths.
- Sub-module mem_arb_grant: pure grant selection plus the saturating starve_cnt register. Inputs are the two valids and a grant strobe; outputs are grant_if and grant_lsu.
- The top holds the FSM, request register, drop flag, response routing and protocol_err.

## Test plan
- Single fetch: if_req_addr=0x8000_0000, memory ready immediately, response 0x0000_0013 at cycle 2 → if_resp_valid=1 with data 0x13 at cycle 2, if_req_ready again at cycle 3.
- Simultaneous IF+LSU in IDLE: LSU load at 0x100 wins → lsu_resp_rdata equals memory data. The IF grant follows in the next IDLE cycle.
- Starvation: IF held valid, LSU issues 6 back-to-back requests, STARVE_LIMIT=4 → grants LSU×4, IF, LSU×2.
- Store with mem_req_ready low 3 cycles: mem_req_addr/wdata/wstrb=0xF held stable through the stall → lsu_resp_valid on the ack, mem_req_wen=1.
- Flush: if_flush pulsed during WAIT → memory completes, if_resp_valid stays 0, next grant proceeds normally.
- Errors and reset: mem_resp_valid in IDLE → protocol_err=1 and sticky. rst asserted in WAIT → IDLE next cycle, no resp pulse, all outputs at reset values.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the memory port arbiter
package mem_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   typedef enum logic {
      OWNER_IF  = 1'b0,
      OWNER_LSU = 1'b1
   } owner_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              wen;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } mem_req_t;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - LSU-priority grant selection with fetch starvation guard
module mem_arb_grant #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic if_valid,
   input  logic lsu_valid,
   input  logic grant_en,
   output logic grant_if,
   output logic grant_lsu
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_cnt;
   logic          force_if;

   always_comb begin
      force_if  = if_valid && (starve_cnt == LIMIT);
      grant_lsu = grant_en && lsu_valid && !force_if;
      grant_if  = grant_en && if_valid && !grant_lsu;
   end

   // Counts only LSU wins that actually kept a waiting fetch out.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (grant_lsu && if_valid) begin
         if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end else if (grant_if || grant_lsu) begin
         starve_cnt <= '0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding memory port shared by fetch and LSU
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_req_valid,
   output logic                    if_req_ready,
   input  logic [ADDR_WIDTH-1:0]   if_req_addr,
   input  logic                    if_flush,
   output logic                    if_resp_valid,
   output logic [DATA_WIDTH-1:0]   if_resp_data,
   input  logic                    lsu_req_valid,
   output logic                    lsu_req_ready,
   input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
   input  logic                    lsu_req_wen,
   input  logic [DATA_WIDTH-1:0]   lsu_req_wdata,
   input  logic [DATA_WIDTH/8-1:0] lsu_req_wstrb,
   output logic                    lsu_resp_valid,
   output logic [DATA_WIDTH-1:0]   lsu_resp_rdata,
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic [ADDR_WIDTH-1:0]   mem_req_addr,
   output logic                    mem_req_wen,
   output logic [DATA_WIDTH-1:0]   mem_req_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
   input  logic                    mem_resp_valid,
   input  logic [DATA_WIDTH-1:0]   mem_resp_rdata,
   output logic                    protocol_err
);

   state_t state, state_nx;
   owner_t owner;
   logic   drop;
   logic   grant_en, grant_if, grant_lsu, resp_hit;

   mem_arb_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
      .clk       (clk),
      .rst       (rst),
      .if_valid  (if_req_valid),
      .lsu_valid (lsu_req_valid),
      .grant_en  (grant_en),
      .grant_if  (grant_if),
      .grant_lsu (grant_lsu)
   );

   // Reset abandons the transaction at once, so it also masks grants and responses.
   assign grant_en      = (state == IDLE) && !rst;
   assign resp_hit      = (state == WAIT) && mem_resp_valid && !rst;
   assign if_req_ready  = grant_if;
   assign lsu_req_ready = grant_lsu;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (grant_if || grant_lsu) state_nx = REQ;
         REQ:     if (mem_req_ready) state_nx = WAIT;
         WAIT:    if (mem_resp_valid) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      mem_req_valid  = (state == REQ);
      if_resp_valid  = resp_hit && (owner == OWNER_IF) && !drop && !if_flush;
      lsu_resp_valid = resp_hit && (owner == OWNER_LSU);
      if_resp_data   = if_resp_valid  ? mem_resp_rdata : '0;
      lsu_resp_rdata = lsu_resp_valid ? mem_resp_rdata : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner         <= OWNER_IF;
         mem_req_addr  <= '0;
         mem_req_wen   <= 1'b0;
         mem_req_wdata <= '0;
         mem_req_wstrb <= '0;
         drop          <= 1'b0;
         protocol_err  <= 1'b0;
      end else begin
         if (grant_lsu) begin
            owner         <= OWNER_LSU;
            mem_req_addr  <= lsu_req_addr;
            mem_req_wen   <= lsu_req_wen;
            mem_req_wdata <= lsu_req_wdata;
            mem_req_wstrb <= lsu_req_wstrb;
         end else if (grant_if) begin
            owner         <= OWNER_IF;
            mem_req_addr  <= if_req_addr;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
         end
         if (state == WAIT && mem_resp_valid)
            drop <= 1'b0;
         else if ((state == REQ || state == WAIT) && owner == OWNER_IF && if_flush)
            drop <= 1'b1;
         if (mem_resp_valid && state != WAIT)
            protocol_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench against a transaction-level model
module tb_mem_port_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;
   localparam int LIM = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req_valid, if_req_ready, if_flush, if_resp_valid;
   logic [AW-1:0] if_req_addr;
   logic [DW-1:0] if_resp_data;
   logic          lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid;
   logic [AW-1:0] lsu_req_addr;
   logic [DW-1:0] lsu_req_wdata, lsu_resp_rdata;
   logic [SW-1:0] lsu_req_wstrb;
   logic          mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
   logic [AW-1:0] mem_req_addr;
   logic [DW-1:0] mem_req_wdata, mem_resp_rdata;
   logic [SW-1:0] mem_req_wstrb;
   logic          protocol_err;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
      .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
      .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
      .protocol_err(protocol_err)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Transaction-level view: one job in flight, memory has or has not taken it yet.
   bit            busy, accepted, m_lsu, drop, perr;
   int            streak;
   logic [AW-1:0] e_addr;
   logic          e_wen;
   logic [DW-1:0] e_wdata;
   logic [SW-1:0] e_wstrb;
   bit            grants[$];
   bit            last_g_if, last_g_lsu, last_if_resp, last_lsu_resp;
   logic [DW-1:0] last_if_data;

   task automatic step();
      bit g_if, g_lsu, resp, exp_if_resp;
      #3;
      g_lsu = !busy && !rst && lsu_req_valid && !(if_req_valid && streak >= LIM);
      g_if  = !busy && !rst && if_req_valid && !g_lsu;
      resp  = busy && accepted && mem_resp_valid && !rst;
      exp_if_resp = resp && !m_lsu && !drop && !if_flush;
      check_eq("if_req_ready", if_req_ready, g_if);
      check_eq("lsu_req_ready", lsu_req_ready, g_lsu);
      check_eq("mem_req_valid", mem_req_valid, busy && !accepted);
      if (busy && !accepted) begin
         check_eq("mem_req_addr", mem_req_addr, e_addr);
         check_eq("mem_req_wen", mem_req_wen, e_wen);
         check_eq("mem_req_wdata", mem_req_wdata, e_wdata);
         check_eq("mem_req_wstrb", mem_req_wstrb, e_wstrb);
      end
      check_eq("if_resp_valid", if_resp_valid, exp_if_resp);
      check_eq("lsu_resp_valid", lsu_resp_valid, resp && m_lsu);
      if (exp_if_resp) check_eq("if_resp_data", if_resp_data, mem_resp_rdata);
      if (resp && m_lsu) check_eq("lsu_resp_rdata", lsu_resp_rdata, mem_resp_rdata);
      check_eq("protocol_err", protocol_err, perr);
      last_g_if     = g_if;
      last_g_lsu    = g_lsu;
      last_if_resp  = if_resp_valid;
      last_lsu_resp = lsu_resp_valid;
      last_if_data  = if_resp_data;
      @(posedge clk);
      if (rst) begin
         busy = 0; accepted = 0; drop = 0; perr = 0; streak = 0;
      end else begin
         if (mem_resp_valid && !(busy && accepted)) perr = 1;
         if (busy && !m_lsu && if_flush) drop = 1;
         if (resp) busy = 0;
         else if (busy && !accepted && mem_req_ready) accepted = 1;
         if (g_if || g_lsu) begin
            busy = 1; accepted = 0; drop = 0; m_lsu = g_lsu;
            grants.push_back(g_lsu);
            if (g_lsu) begin
               e_addr = lsu_req_addr; e_wen = lsu_req_wen;
               e_wdata = lsu_req_wdata; e_wstrb = lsu_req_wstrb;
            end else begin
               e_addr = if_req_addr; e_wen = 0; e_wdata = '0; e_wstrb = '0;
            end
            if (g_if || !if_req_valid) streak = 0;
            else streak = (streak < LIM) ? streak + 1 : LIM;
         end
      end
      #1;
   endtask

   // Acts as memory until the in-flight job completes; stall = cycles of ready low in REQ.
   task automatic finish_txn(input int stall);
      int n = 0;
      int s = stall;
      while (busy && n < 50) begin
         mem_req_ready  = !accepted && s == 0;
         if (!accepted && s > 0) s--;
         mem_resp_valid = accepted;
         mem_resp_rdata = $urandom;
         step();
         if (last_g_if)  if_req_valid  = 0;
         if (last_g_lsu) lsu_req_valid = 0;
         n++;
      end
      mem_req_ready  = 0;
      mem_resp_valid = 0;
      check_eq("txn_timeout", busy, 0);
   endtask

   task automatic lsu_set(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input logic [SW-1:0] s);
      lsu_req_valid = 1; lsu_req_addr = a; lsu_req_wen = w; lsu_req_wdata = d; lsu_req_wstrb = s;
   endtask

   initial begin
      bit exp_seq[7];
      int lsu_cnt, n;
      exp_seq = '{1, 1, 1, 1, 0, 1, 1};
      rst = 1; if_req_valid = 0; if_req_addr = '0; if_flush = 0;
      lsu_req_valid = 0; lsu_req_addr = '0; lsu_req_wen = 0; lsu_req_wdata = '0; lsu_req_wstrb = '0;
      mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
      busy = 0; accepted = 0; m_lsu = 0; drop = 0; perr = 0; streak = 0;
      @(posedge clk); #1;
      step(); step();
      check_eq("rst_mem_addr", mem_req_addr, 0);
      check_eq("rst_mem_wdata", mem_req_wdata, 0);
      rst = 0;
      step();

      // single fetch at minimum latency
      if_req_valid = 1; if_req_addr = 32'h8000_0000; mem_req_ready = 1;
      step();
      check_eq("fetch_c0_grant", last_g_if, 1);
      if_req_valid = 0;
      step();
      mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h0000_0013;
      step();
      check_eq("fetch_c2_valid", last_if_resp, 1);
      check_eq("fetch_c2_data", last_if_data, 32'h13);
      mem_resp_valid = 0; if_req_valid = 1; if_req_addr = 32'h8000_0004;
      step();
      check_eq("fetch_c3_ready", last_g_if, 1);
      if_req_valid = 0;
      finish_txn(0);

      // simultaneous requests: LSU first, then IF
      grants.delete();
      if_req_valid = 1; if_req_addr = 32'h8000_0008;
      lsu_set(32'h100, 0, '0, '0);
      step();
      lsu_req_valid = 0;
      finish_txn(0);
      step();
      if_req_valid = 0;
      finish_txn(0);
      check_eq("sim_count", grants.size(), 2);
      if (grants.size() == 2) begin
         check_eq("sim_first_lsu", grants[0], 1);
         check_eq("sim_second_if", grants[1], 0);
      end

      // starvation guard
      grants.delete();
      lsu_cnt = 0; n = 0;
      if_req_valid = 1; if_req_addr = $urandom;
      lsu_set($urandom, 0, '0, '0);
      while (grants.size() < 7 && n < 200) begin
         mem_req_ready  = busy && !accepted;
         mem_resp_valid = busy && accepted;
         mem_resp_rdata = $urandom;
         step();
         if (last_g_lsu) begin
            lsu_cnt++;
            lsu_req_valid = (lsu_cnt < 6);
            lsu_req_addr  = $urandom;
         end
         if (last_g_if) if_req_addr = $urandom;
         n++;
      end
      if_req_valid = 0; lsu_req_valid = 0;
      finish_txn(0);
      check_eq("starve_count", grants.size() >= 7, 1);
      for (int i = 0; i < 7 && i < grants.size(); i++)
         check_eq($sformatf("starve_grant%0d", i), grants[i], exp_seq[i]);

      // store stalled three cycles by memory
      lsu_set(32'h200, 1, 32'hdead_beef, 4'hf);
      step();
      lsu_req_valid = 0; mem_req_ready = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("store_wen_held", mem_req_wen, 1);
         check_eq("store_wstrb_held", mem_req_wstrb, 4'hf);
      end
      finish_txn(0);
      check_eq("store_ack", last_lsu_resp, 1);

      // flush during WAIT swallows the response
      if_req_valid = 1; if_req_addr = 32'h8000_0100;
      step();
      if_req_valid = 0; mem_req_ready = 1;
      step();
      mem_req_ready = 0; if_flush = 1;
      step();
      if_flush = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h1234_5678;
      step();
      check_eq("flush_no_resp", last_if_resp, 0);
      mem_resp_valid = 0;
      if_req_valid = 1; if_req_addr = 32'h8000_0200;
      step();
      if_req_valid = 0;
      finish_txn(1);
      check_eq("post_flush_resp", last_if_resp, 1);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         if (!if_req_valid && $urandom_range(2) == 0) begin
            if_req_valid = 1; if_req_addr = $urandom;
         end
         if (!lsu_req_valid && $urandom_range(2) == 0)
            lsu_set($urandom, 1'($urandom_range(1)), $urandom, 4'($urandom_range(15)));
         if_flush       = ($urandom_range(7) == 0);
         mem_req_ready  = 1'($urandom_range(1));
         mem_resp_valid = busy && accepted && ($urandom_range(1) == 1);
         mem_resp_rdata = $urandom;
         step();
         if (last_g_if)  if_req_valid  = 0;
         if (last_g_lsu) lsu_req_valid = 0;
      end
      if_req_valid = 0; lsu_req_valid = 0; if_flush = 0;
      finish_txn(0);

      // stray response in IDLE is sticky
      mem_resp_valid = 1; mem_resp_rdata = $urandom;
      step();
      mem_resp_valid = 0;
      step(); step();
      check_eq("perr_sticky", protocol_err, 1);

      // reset while waiting for a load response
      lsu_set(32'h300, 0, '0, '0);
      step();
      lsu_req_valid = 0; mem_req_ready = 1;
      step();
      mem_req_ready = 0; rst = 1; mem_resp_valid = 1; mem_resp_rdata = 32'hcafe_f00d;
      step();
      check_eq("rst_wait_no_resp", last_lsu_resp, 0);
      rst = 0; mem_resp_valid = 0;
      step();
      check_eq("rst_wait_perr", protocol_err, 0);
      check_eq("rst_wait_mem_valid", mem_req_valid, 0);
      check_eq("rst_wait_mem_addr", mem_req_addr, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
